// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch queue: drives the instruction-memory word address, captures
// the two returned words tagged with their PCs into a circular buffer, and
// presents the two oldest entries to decode. Redirects flush and reload the PC.

// One output lane: masks the raw storage entry when the slot is not occupied.
module dual_fetch_queue_slot (
  input  logic        vld,
  input  logic [31:0] instr,
  input  logic [7:0]  pc,
  output logic [31:0] o_instr,
  output logic [7:0]  o_pc
);
  assign o_instr = vld ? instr : '0;
  assign o_pc    = vld ? pc    : '0;
endmodule

module dual_fetch_queue #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [7:0]               fetch_addr,
  input  logic [31:0]              instr1_in,
  input  logic [31:0]              instr2_in,
  input  logic                     redirect_valid,
  input  logic [7:0]               redirect_addr,
  input  logic [1:0]               deq_count,
  output logic                     out_valid0,
  output logic [31:0]              out_instr0,
  output logic [7:0]               out_pc0,
  output logic                     out_valid1,
  output logic [31:0]              out_instr1,
  output logic [7:0]               out_pc1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ent_t;

  ent_t mem [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [CW-1:0] free, deq_req, deq_eff, enq;
  logic          wrap;

  logic [NUM_LANES-1:0]         wr_en;
  logic [NUM_LANES-1:0][AW-1:0] wr_idx;
  ent_t [NUM_LANES-1:0]         wr_ent;

  logic [NUM_LANES-1:0]         slot_vld;
  logic [NUM_LANES-1:0][AW-1:0] rd_idx;
  ent_t [NUM_LANES-1:0]         rd_ent;
  logic [NUM_LANES-1:0][31:0]   o_instr;
  logic [NUM_LANES-1:0][7:0]    o_pc;

  assign count = cnt;

  // Dequeue clamp and enqueue decision; free space is taken before this
  // cycle's dequeue so freed slots are never reused in the same cycle.
  always_comb begin
    free    = CW'(DEPTH) - cnt;
    deq_req = (deq_count == 2'd0) ? '0 : (deq_count == 2'd1) ? CW'(1) : CW'(2);
    deq_eff = (deq_req > cnt) ? cnt : deq_req;
    wrap    = (fetch_addr == 8'hFF);
    enq     = '0;
    if (!redirect_valid) begin
      if (wrap) begin
        if (free >= CW'(1)) enq = CW'(1);
      end else if (free >= CW'(2)) begin
        enq = CW'(2);
      end
    end
  end

  // Write lanes: lane 0 takes the word at fetch_addr, lane 1 its successor.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_idx[l] = tail + AW'(l);
      wr_en[l]  = (enq > CW'(l));
    end
    wr_ent[0] = '{instr: instr1_in, pc: fetch_addr};
    wr_ent[1] = '{instr: instr2_in, pc: fetch_addr + 8'd1};
  end

  // Queue storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (wr_en[l]) mem[wr_idx[l]] <= wr_ent[l];
  end

  // Pointer, occupancy and fetch-address state; redirect outranks everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
    end else if (redirect_valid) begin
      fetch_addr <= redirect_addr;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
    end else begin
      head <= head + AW'(deq_eff);
      tail <= tail + AW'(enq);
      cnt  <= cnt + enq - deq_eff;
      if (enq == CW'(1))      fetch_addr <= 8'd0;
      else if (enq == CW'(2)) fetch_addr <= fetch_addr + 8'd2;
    end
  end

  // Read lanes: slot l shows entry head+l, valid while occupancy exceeds l.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      rd_idx[l]   = head + AW'(l);
      slot_vld[l] = (cnt > CW'(l));
      rd_ent[l]   = mem[rd_idx[l]];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
    dual_fetch_queue_slot u_slot (
      .vld     (slot_vld[g]),
      .instr   (rd_ent[g].instr),
      .pc      (rd_ent[g].pc),
      .o_instr (o_instr[g]),
      .o_pc    (o_pc[g])
    );
  end

  assign out_valid0 = slot_vld[0];
  assign out_instr0 = o_instr[0];
  assign out_pc0    = o_pc[0];
  assign out_valid1 = slot_vld[1];
  assign out_instr1 = o_instr[1];
  assign out_pc1    = o_pc[1];

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Bench for dual_fetch_queue: directed vector table, async reset sequence,
// then random traffic checked against a queue-based reference model.
module tb_dual_fetch_queue;
  localparam int DEPTH = 8;

  logic        clk, rst;
  logic [7:0]  fetch_addr;
  logic [31:0] instr1_in, instr2_in;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic [1:0]  deq_count;
  logic        out_valid0, out_valid1;
  logic [31:0] out_instr0, out_instr1;
  logic [7:0]  out_pc0, out_pc1;
  logic [3:0]  count;

  logic [31:0] imem [256];
  int errors = 0;
  int checks = 0;

  dual_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr),
    .instr1_in(instr1_in), .instr2_in(instr2_in),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .deq_count(deq_count),
    .out_valid0(out_valid0), .out_instr0(out_instr0), .out_pc0(out_pc0),
    .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1),
    .count(count)
  );

  // combinational instruction memory
  assign instr1_in = imem[fetch_addr];
  assign instr2_in = imem[8'(fetch_addr + 8'd1)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // occupancy bound, every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (count > 4'(DEPTH)) begin
        errors++;
        $display("FAIL count_bound actual=%0d expected<=%0d", count, DEPTH);
      end
    end
  end

  // reference model: a plain queue of {instr, pc} plus the fetch pointer
  typedef struct { logic [31:0] instr; logic [7:0] pc; } ment_t;
  ment_t       mq[$];
  logic [7:0]  mfa;

  task automatic model_step(input logic r, input logic [7:0] a, input logic [1:0] d);
    int n, dn, fr;
    logic [7:0] nx;
    n  = mq.size();
    dn = (d == 2'd3) ? 2 : int'(d);
    if (dn > n) dn = n;
    fr = DEPTH - n;
    if (r) begin
      mq.delete();
      mfa = a;
    end else begin
      repeat (dn) void'(mq.pop_front());
      if (mfa == 8'hFF) begin
        if (fr >= 1) begin
          mq.push_back('{imem[255], 8'hFF});
          mfa = 8'd0;
        end
      end else if (fr >= 2) begin
        nx = mfa + 8'd1;
        mq.push_back('{imem[mfa], mfa});
        mq.push_back('{imem[nx], nx});
        mfa = mfa + 8'd2;
      end
    end
  endtask

  task automatic model_chk();
    int n;
    n = mq.size();
    chk("m_count", 32'(count), 32'(n));
    chk("m_fetch_addr", 32'(fetch_addr), 32'(mfa));
    chk("m_valid0", 32'(out_valid0), 32'(n >= 1));
    chk("m_instr0", out_instr0, (n >= 1) ? mq[0].instr : 32'd0);
    chk("m_pc0", 32'(out_pc0), (n >= 1) ? 32'(mq[0].pc) : 32'd0);
    chk("m_valid1", 32'(out_valid1), 32'(n >= 2));
    chk("m_instr1", out_instr1, (n >= 2) ? mq[1].instr : 32'd0);
    chk("m_pc1", 32'(out_pc1), (n >= 2) ? 32'(mq[1].pc) : 32'd0);
  endtask

  // apply inputs, clock once, settle away from the edge
  task automatic drive(input logic r, input logic [7:0] a, input logic [1:0] d);
    redirect_valid = r;
    redirect_addr  = a;
    deq_count      = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rv;
    logic [7:0] ra;
    logic [1:0] dq;
    int         cnt;
    logic [7:0] fa;
    logic       v0;
    logic [7:0] pc0;
    logic       v1;
    logic [7:0] pc1;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // directed phase: word[i] = i, so an instruction equals its pc
    for (int i = 0; i < 256; i++) imem[i] = 32'(i);
    tbl[0]  = '{0, 8'h00, 2'd0, 2, 8'h02, 1, 8'h00, 1, 8'h01};
    tbl[1]  = '{0, 8'h00, 2'd0, 4, 8'h04, 1, 8'h00, 1, 8'h01};
    tbl[2]  = '{0, 8'h00, 2'd0, 6, 8'h06, 1, 8'h00, 1, 8'h01};
    tbl[3]  = '{0, 8'h00, 2'd0, 8, 8'h08, 1, 8'h00, 1, 8'h01};
    tbl[4]  = '{0, 8'h00, 2'd0, 8, 8'h08, 1, 8'h00, 1, 8'h01};
    tbl[5]  = '{0, 8'h00, 2'd2, 6, 8'h08, 1, 8'h02, 1, 8'h03};
    tbl[6]  = '{0, 8'h00, 2'd2, 6, 8'h0A, 1, 8'h04, 1, 8'h05};
    tbl[7]  = '{0, 8'h00, 2'd2, 6, 8'h0C, 1, 8'h06, 1, 8'h07};
    tbl[8]  = '{0, 8'h00, 2'd2, 6, 8'h0E, 1, 8'h08, 1, 8'h09};
    tbl[9]  = '{0, 8'h00, 2'd1, 7, 8'h10, 1, 8'h09, 1, 8'h0A};
    tbl[10] = '{0, 8'h00, 2'd2, 5, 8'h10, 1, 8'h0B, 1, 8'h0C};
    tbl[11] = '{1, 8'h41, 2'd2, 0, 8'h41, 0, 8'h00, 0, 8'h00};
    tbl[12] = '{0, 8'h00, 2'd2, 2, 8'h43, 1, 8'h41, 1, 8'h42};
    tbl[13] = '{1, 8'hFE, 2'd0, 0, 8'hFE, 0, 8'h00, 0, 8'h00};
    tbl[14] = '{0, 8'h00, 2'd0, 2, 8'h00, 1, 8'hFE, 1, 8'hFF};
    tbl[15] = '{1, 8'hFF, 2'd0, 0, 8'hFF, 0, 8'h00, 0, 8'h00};
    tbl[16] = '{0, 8'h00, 2'd0, 1, 8'h00, 1, 8'hFF, 0, 8'h00};
    tbl[17] = '{0, 8'h00, 2'd3, 2, 8'h02, 1, 8'h00, 1, 8'h01};
    tbl[18] = '{1, 8'hFF, 2'd0, 0, 8'hFF, 0, 8'h00, 0, 8'h00};
    tbl[19] = '{0, 8'h00, 2'd0, 1, 8'h00, 1, 8'hFF, 0, 8'h00};
    tbl[20] = '{0, 8'h00, 2'd2, 2, 8'h02, 1, 8'h00, 1, 8'h01};

    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'h00;
    deq_count      = 2'd0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_fetch_addr", 32'(fetch_addr), 32'd0);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_instr0", out_instr0, 32'd0);
    chk("rst_pc1", 32'(out_pc1), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].dq);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_fetch_addr", i), 32'(fetch_addr), 32'(tbl[i].fa));
      chk($sformatf("v%0d_valid0", i), 32'(out_valid0), 32'(tbl[i].v0));
      chk($sformatf("v%0d_pc0", i), 32'(out_pc0), 32'(tbl[i].pc0));
      chk($sformatf("v%0d_instr0", i), out_instr0, 32'(tbl[i].pc0));
      chk($sformatf("v%0d_valid1", i), 32'(out_valid1), 32'(tbl[i].v1));
      chk($sformatf("v%0d_pc1", i), 32'(out_pc1), 32'(tbl[i].pc1));
      chk($sformatf("v%0d_instr1", i), out_instr1, 32'(tbl[i].pc1));
    end

    // fill to 6, then reset mid-cycle and check it lands without a clock edge
    drive(1'b0, 8'h00, 2'd0);
    drive(1'b0, 8'h00, 2'd0);
    chk("pre_areset_count", 32'(count), 32'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid0", 32'(out_valid0), 32'd0);
    chk("areset_valid1", 32'(out_valid1), 32'd0);
    chk("areset_pc0", 32'(out_pc0), 32'd0);
    chk("areset_fetch_addr", 32'(fetch_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("refill_count", 32'(count), 32'd2);
    chk("refill_fetch_addr", 32'(fetch_addr), 32'd2);
    chk("refill_pc1", 32'(out_pc1), 32'd1);

    // random phase: fresh memory contents, reset, then model-checked traffic
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    mq.delete();
    mfa = 8'h00;
    #1;
    model_chk();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic       r;
      logic [7:0] a;
      logic [1:0] d;
      r = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       a = 8'hFF;
        1:       a = 8'hFE;
        default: a = 8'($urandom);
      endcase
      d = 2'($urandom_range(0, 3));
      model_step(r, a, d);
      drive(r, a, d);
      model_chk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
